// File: rtl/phase_scheduler_if.sv
// phase_scheduler_if
// Groups the intersection sensor inputs and the light/walk outputs of the
// phase scheduler into one bundle. Signal suffixes are named from the
// scheduler's point of view.
//   s1_i    NB 4th Ave vehicle sensor (level)
//   s2_i    EB Harrison vehicle sensor (level)
//   s3_i    WB Harrison vehicle sensor (level)
//   p_i     pedestrian push button (any-width pulse)
//   l1_o    NB light    (00 flash, 01 green, 10 yellow, 11 red)
//   l2_o    EB light
//   l3_o    WB light (mirrors l2_o)
//   w_o     walk indication
//   phase_o served phase (00 NB, 01 EW, 10 PED)
// master: drives the sensors and button (intersection / testbench side)
// slave : the scheduler itself
interface phase_scheduler_if;
  logic       s1_i;
  logic       s2_i;
  logic       s3_i;
  logic       p_i;
  logic [1:0] l1_o;
  logic [1:0] l2_o;
  logic [1:0] l3_o;
  logic       w_o;
  logic [1:0] phase_o;

  modport master (
    output s1_i, s2_i, s3_i, p_i,
    input  l1_o, l2_o, l3_o, w_o, phase_o
  );

  modport slave (
    input  s1_i, s2_i, s3_i, p_i,
    output l1_o, l2_o, l3_o, w_o, phase_o
  );
endinterface

// File: rtl/phase_scheduler.sv
// phase_scheduler
// Three-phase (NB, EW, PED) actuated traffic light scheduler. One clock
// cycle is one second. All outputs are registered and change together with
// the state register.
// Ports:
//   clk_i  single clock, all logic on posedge
//   rst_i  synchronous active-high reset
//   bus    phase_scheduler_if.slave: sensors/button in, lights/walk/phase out
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FLASH  | reset state, all lights 00; lasts one cycle after reset
// ST_CLEAR  | all-red clearance for ALL_RED cycles, then serve next_q
// ST_GREEN  | served vehicle phase green; g_q counts elapsed cycles
// ST_YELLOW | served vehicle phase yellow for YELLOW cycles
// ST_WALK   | all red, walk lit for WALK cycles
module phase_scheduler #(
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 44,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 1,
  parameter int unsigned WALK      = 7
) (
  input logic              clk_i,
  input logic              rst_i,
  phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    ST_FLASH,
    ST_CLEAR,
    ST_GREEN,
    ST_YELLOW,
    ST_WALK
  } state_t;

  localparam logic [1:0] LT_FLASH  = 2'b00;
  localparam logic [1:0] LT_GREEN  = 2'b01;
  localparam logic [1:0] LT_YELLOW = 2'b10;
  localparam logic [1:0] LT_RED    = 2'b11;

  localparam logic [1:0] PH_NB  = 2'b00;
  localparam logic [1:0] PH_EW  = 2'b01;
  localparam logic [1:0] PH_PED = 2'b10;

  localparam logic [7:0] MIN_G = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_G = 8'(MAX_GREEN);
  localparam logic [7:0] YEL_C = 8'(YELLOW);
  localparam logic [7:0] AR_C  = 8'(ALL_RED);
  localparam logic [7:0] WLK_C = 8'(WALK);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [7:0] g_q;
  logic [1:0] phase_q;
  logic [1:0] next_q;
  logic [1:0] l1_q;
  logic [1:0] l2_q;
  logic       w_q;
  logic       ped_q;

  logic       d_nb, d_ew, d_ped;
  logic       own_dem, comp_dem;
  logic       green_exit;
  logic [1:0] next_green_d;
  logic [1:0] next_walk_d;
  logic       ped_d;

  always_comb begin
    d_nb  = bus.s1_i;
    d_ew  = bus.s2_i | bus.s3_i;
    d_ped = ped_q;

    own_dem      = d_nb;
    comp_dem     = d_ew | d_ped;
    next_green_d = d_ew ? PH_EW : (d_ped ? PH_PED : PH_NB);
    if (phase_q == PH_EW) begin
      own_dem      = d_ew;
      comp_dem     = d_nb | d_ped;
      next_green_d = d_ped ? PH_PED : (d_nb ? PH_NB : PH_EW);
    end

    green_exit = (g_q >= MIN_G) && comp_dem && (!own_dem || (g_q == MAX_G));

    // After a walk the NB approach is the rest phase.
    next_walk_d = (!d_nb && d_ew) ? PH_EW : PH_NB;

    // The first walk cycle clears the request and masks a press in that cycle.
    if ((state_q == ST_WALK) && (cnt_q == WLK_C)) begin
      ped_d = 1'b0;
    end else begin
      ped_d = ped_q | bus.p_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FLASH;
      cnt_q   <= '0;
      g_q     <= '0;
      phase_q <= PH_NB;
      next_q  <= PH_NB;
      l1_q    <= LT_FLASH;
      l2_q    <= LT_FLASH;
      w_q     <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      ped_q <= ped_d;
      case (state_q)
        ST_FLASH: begin
          state_q <= ST_CLEAR;
          cnt_q   <= AR_C;
          next_q  <= PH_NB;
          l1_q    <= LT_RED;
          l2_q    <= LT_RED;
          w_q     <= 1'b0;
        end
        ST_CLEAR: begin
          if (cnt_q == 8'd1) begin
            if (next_q == PH_PED) begin
              state_q <= ST_WALK;
              cnt_q   <= WLK_C;
              phase_q <= PH_PED;
              w_q     <= 1'b1;
            end else begin
              state_q <= ST_GREEN;
              g_q     <= 8'd1;
              phase_q <= next_q;
              if (next_q == PH_NB) l1_q <= LT_GREEN;
              else                 l2_q <= LT_GREEN;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_GREEN: begin
          if (green_exit) begin
            state_q <= ST_YELLOW;
            cnt_q   <= YEL_C;
            next_q  <= next_green_d;
            if (phase_q == PH_NB) l1_q <= LT_YELLOW;
            else                  l2_q <= LT_YELLOW;
          end else if (g_q != MAX_G) begin
            g_q <= g_q + 8'd1;
          end
        end
        ST_YELLOW: begin
          if (cnt_q == 8'd1) begin
            state_q <= ST_CLEAR;
            cnt_q   <= AR_C;
            l1_q    <= LT_RED;
            l2_q    <= LT_RED;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_WALK: begin
          if (cnt_q == 8'd1) begin
            state_q <= ST_CLEAR;
            cnt_q   <= AR_C;
            w_q     <= 1'b0;
            next_q  <= next_walk_d;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_FLASH;
          l1_q    <= LT_FLASH;
          l2_q    <= LT_FLASH;
          w_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.l1_o    = l1_q;
  assign bus.l2_o    = l2_q;
  assign bus.l3_o    = l2_q;
  assign bus.w_o     = w_q;
  assign bus.phase_o = phase_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler
// Scoreboard bench for phase_scheduler: each scenario pushes per-cycle
// entries (inputs to drive in that cycle + the outputs expected in it),
// then pops them one clock at a time and compares against the DUT.
module tb_phase_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phase_scheduler_if bus ();
  phase_scheduler dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic [4:0] in;   // {rst, s1, s2, s3, p}
    logic [8:0] exp;  // {l1, l2, l3, w, phase}
  } entry_t;

  entry_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [1:0] FL = 2'b00, GR = 2'b01, YL = 2'b10, RD = 2'b11;
  localparam logic [1:0] PNB = 2'b00, PEW = 2'b01, PPD = 2'b10;
  localparam logic [4:0] I_0 = 5'b00000, I_R = 5'b10000, I_S1 = 5'b01000;
  localparam logic [4:0] I_S2 = 5'b00100, I_S3 = 5'b00010, I_P = 5'b00001;

  task automatic push(input int n, input logic [1:0] l1, input logic [1:0] l2,
                      input logic w, input logic [1:0] ph, input logic [4:0] in);
    entry_t e;
    e.in  = in;
    e.exp = {l1, l2, l2, w, ph};
    for (int k = 0; k < n; k++) sb.push_back(e);
  endtask

  task automatic drive(input logic [4:0] in);
    rst = in[4];
    bus.s1_i = in[3];
    bus.s2_i = in[2];
    bus.s3_i = in[1];
    bus.p_i  = in[0];
  endtask

  // Sample one cycle's outputs, then drive that cycle's inputs.
  task automatic step(output entry_t e, output logic [8:0] obs);
    @(posedge clk); #1;
    obs = {bus.l1_o, bus.l2_o, bus.l3_o, bus.w_o, bus.phase_o};
    e = sb.pop_front();
    drive(e.in);
  endtask

  // Reset for two cycles, then release with the given sensors for the FLASH cycle.
  task automatic reset_dut(input logic [4:0] in);
    @(posedge clk); #1;
    drive(I_R);
    repeat (2) @(posedge clk);
    #1;
    drive(in);
  endtask

  task automatic test_reset();
    entry_t e;
    logic [8:0] obs;
    int i;
    @(posedge clk); #1;
    drive(I_R);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      obs = {bus.l1_o, bus.l2_o, bus.l3_o, bus.w_o, bus.phase_o};
      n_chk++;
      if (obs !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b want %b", k, obs, 9'b0);
      end
    end
    drive(I_0);
    push(1, RD, RD, 1'b0, PNB, I_0);
    push(5, GR, RD, 1'b0, PNB, I_0);
    i = 0;
    while (sb.size() != 0) begin
      step(e, obs);
      n_chk++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %b want %b", i, obs, e.exp);
      end
      i++;
    end
  endtask

  task automatic test_nb_hold();
    entry_t e;
    logic [8:0] obs;
    int i;
    reset_dut(I_S1);
    push(1,   RD, RD, 1'b0, PNB, I_S1);
    push(100, GR, RD, 1'b0, PNB, I_S1);
    i = 0;
    while (sb.size() != 0) begin
      step(e, obs);
      n_chk++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL nb_hold[%0d]: got %b want %b", i, obs, e.exp);
      end
      i++;
    end
  endtask

  task automatic test_max_green();
    entry_t e;
    logic [8:0] obs;
    int i;
    reset_dut(I_S1);
    push(1,  RD, RD, 1'b0, PNB, I_S1);
    push(4,  GR, RD, 1'b0, PNB, I_S1);
    push(40, GR, RD, 1'b0, PNB, I_S1 | I_S2);
    push(3,  YL, RD, 1'b0, PNB, I_S1 | I_S2);
    push(1,  RD, RD, 1'b0, PNB, I_S1 | I_S2);
    push(5,  RD, GR, 1'b0, PEW, I_S1 | I_S2);
    i = 0;
    while (sb.size() != 0) begin
      step(e, obs);
      n_chk++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL max_green[%0d]: got %b want %b", i, obs, e.exp);
      end
      i++;
    end
  endtask

  task automatic test_min_green();
    entry_t e;
    logic [8:0] obs;
    int i;
    reset_dut(I_S1);
    push(1, RD, RD, 1'b0, PNB, I_S1);
    push(2, GR, RD, 1'b0, PNB, I_S1);
    push(8, GR, RD, 1'b0, PNB, I_S3);
    push(3, YL, RD, 1'b0, PNB, I_S3);
    push(1, RD, RD, 1'b0, PNB, I_S3);
    push(5, RD, GR, 1'b0, PEW, I_S3);
    i = 0;
    while (sb.size() != 0) begin
      step(e, obs);
      n_chk++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL min_green[%0d]: got %b want %b", i, obs, e.exp);
      end
      i++;
    end
  endtask

  task automatic test_ped_walk();
    entry_t e;
    logic [8:0] obs;
    int i;
    reset_dut(I_S2);
    push(1,  RD, RD, 1'b0, PNB, I_S2);
    push(10, GR, RD, 1'b0, PNB, I_S2);
    push(3,  YL, RD, 1'b0, PNB, I_S2);
    push(1,  RD, RD, 1'b0, PNB, I_S2);
    push(1,  RD, GR, 1'b0, PEW, I_0);
    push(1,  RD, GR, 1'b0, PEW, I_P);
    push(8,  RD, GR, 1'b0, PEW, I_0);
    push(3,  RD, YL, 1'b0, PEW, I_0);
    push(1,  RD, RD, 1'b0, PEW, I_0);
    push(7,  RD, RD, 1'b1, PPD, I_0);
    push(1,  RD, RD, 1'b0, PPD, I_0);
    push(5,  GR, RD, 1'b0, PNB, I_0);
    i = 0;
    while (sb.size() != 0) begin
      step(e, obs);
      n_chk++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL ped_walk[%0d]: got %b want %b", i, obs, e.exp);
      end
      i++;
    end
  endtask

  task automatic test_ped_relatch();
    entry_t e;
    logic [8:0] obs;
    int i;
    // Press on the first walk cycle is swallowed: NB rests afterwards.
    reset_dut(I_0);
    push(1,  RD, RD, 1'b0, PNB, I_P);
    push(10, GR, RD, 1'b0, PNB, I_0);
    push(3,  YL, RD, 1'b0, PNB, I_0);
    push(1,  RD, RD, 1'b0, PNB, I_0);
    push(1,  RD, RD, 1'b1, PPD, I_P);
    push(6,  RD, RD, 1'b1, PPD, I_0);
    push(1,  RD, RD, 1'b0, PPD, I_0);
    push(15, GR, RD, 1'b0, PNB, I_0);
    i = 0;
    while (sb.size() != 0) begin
      step(e, obs);
      n_chk++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL ped_entry_press[%0d]: got %b want %b", i, obs, e.exp);
      end
      i++;
    end
    // Press on walk cycle 3 is latched: a second walk follows NB green.
    reset_dut(I_0);
    push(1,  RD, RD, 1'b0, PNB, I_P);
    push(10, GR, RD, 1'b0, PNB, I_0);
    push(3,  YL, RD, 1'b0, PNB, I_0);
    push(1,  RD, RD, 1'b0, PNB, I_0);
    push(2,  RD, RD, 1'b1, PPD, I_0);
    push(1,  RD, RD, 1'b1, PPD, I_P);
    push(4,  RD, RD, 1'b1, PPD, I_0);
    push(1,  RD, RD, 1'b0, PPD, I_0);
    push(10, GR, RD, 1'b0, PNB, I_0);
    push(3,  YL, RD, 1'b0, PNB, I_0);
    push(1,  RD, RD, 1'b0, PNB, I_0);
    push(7,  RD, RD, 1'b1, PPD, I_0);
    push(1,  RD, RD, 1'b0, PPD, I_0);
    push(5,  GR, RD, 1'b0, PNB, I_0);
    i = 0;
    while (sb.size() != 0) begin
      step(e, obs);
      n_chk++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL ped_relatch[%0d]: got %b want %b", i, obs, e.exp);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_yellow();
    entry_t e;
    logic [8:0] obs;
    int i;
    reset_dut(I_S2);
    push(1,  RD, RD, 1'b0, PNB, I_S2);
    push(10, GR, RD, 1'b0, PNB, I_S2);
    push(1,  YL, RD, 1'b0, PNB, I_S2);
    push(1,  YL, RD, 1'b0, PNB, I_R | I_S2);
    push(2,  FL, FL, 1'b0, PNB, I_R);
    push(1,  FL, FL, 1'b0, PNB, I_S1);
    push(1,  RD, RD, 1'b0, PNB, I_S1);
    push(5,  GR, RD, 1'b0, PNB, I_S1);
    i = 0;
    while (sb.size() != 0) begin
      step(e, obs);
      n_chk++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL reset_mid_yellow[%0d]: got %b want %b", i, obs, e.exp);
      end
      i++;
    end
  endtask

  initial begin
    drive(I_R);
    test_reset();
    test_nb_hold();
    test_max_green();
    test_min_green();
    test_ped_walk();
    test_ped_relatch();
    test_reset_mid_yellow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter MIN_GREEN, default 10, minimum green cycles per vehicle phase.
REQ-002 Parameter MAX_GREEN, default 44, maximum green cycles when a competing demand exists.
REQ-003 Parameter YELLOW, default 3, yellow cycles.
REQ-004 Parameter ALL_RED, default 1, all-red clearance cycles.
REQ-005 Parameter WALK, default 7, pedestrian walk cycles.
REQ-006 Clock  input  1  single clock, one cycle = 1 s tick, all logic on posedge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 S1  input  1  NB SW 4th Ave vehicle sensor, level.
REQ-009 S2  input  1  EB SW Harrison vehicle sensor, level.
REQ-010 S3  input  1  WB SW Harrison vehicle sensor, level.
REQ-011 P  input  1  pedestrian push button, any-width pulse.
REQ-012 L1  output  2  NB light: 00 flash, 01 green, 10 yellow, 11 red.
REQ-013 L2  output  2  EB light, same encoding.
REQ-014 L3  output  2  WB light, same encoding; always equal to L2.
REQ-015 W  output  1  walk indication.
REQ-016 Phase  output  2  served phase: 00 NB, 01 EW, 10 PED.

Function
REQ-017 States SHALL be FLASH, CLEAR, GREEN, YELLOW, WALK; all outputs registered.
REQ-018 Demands SHALL be dNB=S1, dEW=S2|S3, dPED=ped_pend; ped_pend set by P, cleared on the WALK-entry cycle (clear wins over a simultaneous P); P during later WALK cycles re-sets ped_pend.
REQ-019 FLASH SHALL last exactly one cycle after Reset deasserts, then CLEAR with next phase NB.
REQ-020 CLEAR SHALL hold all lights 11, W=0, for ALL_RED cycles, then enter GREEN (NB/EW) or WALK (PED) of the latched next phase.
REQ-021 GREEN SHALL drive served phase lights 01, others 11; 8-bit elapsed counter g starts at 1 on the first green cycle, saturates at MAX_GREEN.
REQ-022 GREEN exit SHALL occur at the end of a cycle where g>=MIN_GREEN and a competing demand exists and (own demand=0 or g==MAX_GREEN); with no competing demand GREEN holds indefinitely.
REQ-023 Next phase SHALL be latched at GREEN exit: first phase with demand in cyclic order NB->EW->PED->NB, starting after the current phase.
REQ-024 YELLOW SHALL drive served phase lights 10, others 11, for YELLOW cycles, then CLEAR.
REQ-025 WALK SHALL hold all lights 11, W=1, Phase=10, for WALK cycles; next phase = first of NB, EW with demand, else NB (rest phase); then CLEAR.
REQ-026 Phase SHALL update on GREEN/WALK entry and hold through YELLOW and CLEAR.
REQ-027 No two conflicting approaches SHALL ever show non-11 simultaneously outside FLASH; W=1 only when L1=L2=L3=11.
REQ-028 Timers SHALL be 8-bit; parameters range 1..255 with MIN_GREEN<=MAX_GREEN; WALK/YELLOW/ALL_RED count exactly N cycles.

Reset
REQ-029 Reset high at a posedge SHALL force state FLASH, L1=L2=L3=00, W=0, Phase=00, ped_pend=0, counters 0, regardless of state mid-operation.
REQ-030 Reset held high SHALL hold these values; first non-reset cycle is the single FLASH cycle.

Verification
REQ-031 Reset release, S1=1 only -> 1 cycle 00, 1 cycle all 11, then L1=01 held for 100 cycles, L2=L3=11.
REQ-032 NB green, S1=1, S2 asserted at g=5 -> L1=01 until g=44, then 3 cycles L1=10, 1 cycle all 11, L2=L3=01, Phase=01.
REQ-033 NB green, S1 drops at g=3, S3=1 -> L1 yellow starts after g=10, EW green follows.
REQ-034 EW green, 1-cycle P pulse, S1=0 -> after EW min/gap exit: yellow 3, clear 1, W=1 with all 11 for 7 cycles, clear 1, L1=01 (rest).
REQ-035 P pulsed on WALK-entry cycle -> not re-latched; P on WALK cycle 3 -> second WALK served after next vehicle phase.
REQ-036 Reset asserted mid-YELLOW -> next cycle all outputs 00, W=0; sequence restarts per REQ-031.
